// File: rtl/conv_relu_pool.sv
// Post-convolution ReLU and 2x2 stride-2 max-pool stage for a bfloat16 raster stream.
// Single-cycle registered output; half-width line buffer holds even-row pair maxima.
module conv_relu_pool #(
  parameter int unsigned EXP     = 8,
  parameter int unsigned MANT    = 7,
  parameter int unsigned WIDTH   = 1 + EXP + MANT,
  parameter int unsigned MAX_RES = 256
) (
  input  logic             clock,
  input  logic             clock_areset_n,
  input  logic [2:0]       xres_select,
  input  logic             relu_enable,
  input  logic             pool_enable,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic             out_sof,
  output logic             out_eol,
  output logic [WIDTH-1:0] out_data
);

  localparam int unsigned COL_W    = $clog2(MAX_RES);
  localparam int unsigned LB_DEPTH = MAX_RES / 2;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  // Total order key: negatives reversed below all positives, -0 just under +0.
  function automatic logic [WIDTH-1:0] f_key(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? ~x : (x | {1'b1, {(WIDTH-1){1'b0}}});
  endfunction

  // Ties keep the earlier operand.
  function automatic logic [WIDTH-1:0] f_max(input logic [WIDTH-1:0] early,
                                              input logic [WIDTH-1:0] late);
    return (f_key(late) > f_key(early)) ? late : early;
  endfunction

  state_e           r_state;
  logic [2:0]       r_xsel;
  logic             r_relu;
  logic             r_pool;
  logic [COL_W-1:0] r_col;
  logic             r_par;
  logic [WIDTH-1:0] r_pair;
  logic             r_sof_pend;
  logic             r_out_valid;
  logic             r_out_sof;
  logic             r_out_eol;
  logic [WIDTH-1:0] r_out_data;
  logic [WIDTH-1:0] r_lb [LB_DEPTH];

  logic             w_accept;
  logic [2:0]       w_xsel_in;
  logic [2:0]       w_xsel;
  logic             w_relu;
  logic             w_pool;
  logic [COL_W-1:0] w_col;
  logic             w_par;
  logic [COL_W-1:0] w_col_max;
  logic             w_last_col;
  logic [WIDTH-1:0] w_act;
  logic [WIDTH-1:0] w_pair_max;
  logic [COL_W-2:0] w_lb_addr;
  logic [WIDTH-1:0] w_lb_rd;
  logic [WIDTH-1:0] w_pool_out;
  logic             w_emit;
  logic             w_lb_we;

  // A sof word uses the config presented with it and is always pixel (0,0).
  assign w_accept   = in_valid && (in_sof || (r_state == StRun));
  assign w_xsel_in  = (xres_select > 3'd4) ? 3'd4 : xres_select;
  assign w_xsel     = in_sof ? w_xsel_in   : r_xsel;
  assign w_relu     = in_sof ? relu_enable : r_relu;
  assign w_pool     = in_sof ? pool_enable : r_pool;
  assign w_col      = in_sof ? '0   : r_col;
  assign w_par      = in_sof ? 1'b0 : r_par;
  assign w_col_max  = COL_W'((32'd16 << w_xsel) - 32'd1);
  assign w_last_col = (w_col == w_col_max);

  assign w_act      = (w_relu && in_data[WIDTH-1]) ? '0 : in_data;
  assign w_pair_max = f_max(r_pair, w_act);
  assign w_lb_addr  = w_col[COL_W-1:1];
  assign w_lb_rd    = r_lb[w_lb_addr];
  assign w_pool_out = f_max(w_lb_rd, w_pair_max);

  assign w_emit  = w_accept && (!w_pool || (w_col[0] && w_par));
  assign w_lb_we = w_accept && w_pool && w_col[0] && !w_par;

  always_ff @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) begin
      r_state     <= StIdle;
      r_xsel      <= '0;
      r_relu      <= 1'b0;
      r_pool      <= 1'b0;
      r_col       <= '0;
      r_par       <= 1'b0;
      r_pair      <= '0;
      r_sof_pend  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sof   <= 1'b0;
      r_out_eol   <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_out_valid <= w_emit;
      r_out_sof   <= w_emit && (in_sof || r_sof_pend);
      r_out_eol   <= w_emit && w_last_col;
      if (w_emit) begin
        r_out_data <= w_pool ? w_pool_out : w_act;
      end
      if (w_accept) begin
        if (in_sof) begin
          r_state <= StRun;
          r_xsel  <= w_xsel_in;
          r_relu  <= relu_enable;
          r_pool  <= pool_enable;
        end
        r_col      <= w_last_col ? '0 : w_col + COL_W'(1);
        r_par      <= w_last_col ? ~w_par : w_par;
        r_sof_pend <= w_emit ? 1'b0 : (in_sof || r_sof_pend);
        if (!w_col[0]) begin
          r_pair <= w_act;
        end
      end
    end
  end

  // Contents are not reset; every entry is written on the even row before its odd-row read.
  always_ff @(posedge clock) begin
    if (w_lb_we) begin
      r_lb[w_lb_addr] <= w_pair_max;
    end
  end

  assign out_valid = r_out_valid;
  assign out_sof   = r_out_sof;
  assign out_eol   = r_out_eol;
  assign out_data  = r_out_data;

endmodule

// File: doc/conv_relu_pool.md
# conv_relu_pool

Post-convolution activation and 2x2 max-pool stage for the bfloat16 CNN inference pipeline. Consumes the raster-ordered result stream of the convolution calculator, which has no backpressure. Applies optional ReLU, then optional 2x2 stride-2 max pooling using a half-width line buffer. Emits a pooled raster stream with start-of-frame and end-of-line markers to the next layer's buffer writer.

## Interface
- EXP, 8, float exponent bits
- MANT, 7, float mantissa bits
- WIDTH, 1+EXP+MANT, word width
- MAX_RES, 256, largest input row width; line buffer depth MAX_RES/2
- clock  in  1  sole clock, all state on rising edge
- clock_areset_n  in  1  reset, asynchronous and active-low
- xres_select  in  3  input row width W = 16<<xres_select; values >4 treated as 4 (W=256)
- relu_enable  in  1  1 = apply ReLU
- pool_enable  in  1  1 = 2x2 max pool, 0 = pass-through
- in_valid  in  1  input word strobe (from conv result_valid)
- in_sof  in  1  qualifies in_valid: first pixel of a frame
- in_data  in  WIDTH  input word (from conv result)
- out_valid  out  1  output strobe, single-cycle per word
- out_sof  out  1  with out_valid: first output word of frame
- out_eol  out  1  with out_valid: last output word of a row
- out_data  out  WIDTH  output word

## Operation
- States: IDLE, RUN. Reset enters IDLE. Any in_valid && in_sof enters RUN from either state.
- In IDLE, in_valid without in_sof is dropped silently.
- Config capture: xres_select, relu_enable, pool_enable latched on in_valid && in_sof. They are ignored at all other times, so mid-frame changes have no effect.
- sof handling: in_sof clears col and row counters, and the sof word is pixel (0,0). in_sof mid-frame abandons the partial frame; no pending output from it is emitted.
- Counters: col 0..W-1 and row-parity bit. Both advance per accepted word. col wraps at W-1 and toggles parity. No frame height limit; frame ends only by the next sof.
- ReLU, when enabled: any word with sign bit 1 becomes 0x0000 (+0). This includes -0, -inf and negative-sign NaN. Otherwise the word passes unchanged.
- Compare order, total, on post-ReLU words:
  - key = sign ? ~bits : bits | (1<<(WIDTH-1)), compared as unsigned.
  - -0 < +0. +NaN is above +inf. Ties keep the earlier word.
- Pool, even row: on odd col, max(prev, cur) is written to line buffer at col>>1. The even-col word is held in a pair register.
- Pool, odd row: on odd col, the result is max(linebuf[col>>1], max(prev, cur)) and is emitted.
- Output width: W/2 words per output row, one output row per input row pair.
- out_sof marks the first pool output after sof. out_eol marks col==W-1.
- Pass-through (pool_enable=0): every accepted word is emitted after ReLU. out_sof is asserted on the sof word; out_eol on col==W-1.
- Line buffer: single-port inferable RAM or register array, MAX_RES/2 x WIDTH. Read address and write address are both col>>1, so no read/write conflict is possible.

## Timing
- Reset: out_valid=0, out_sof=0, out_eol=0, out_data=0, state IDLE, counters 0, pair register 0.
- Line buffer contents are not reset. They are always written before being read within a frame.
- Latency: out_valid is asserted exactly 1 cycle after the accepted in_valid that completes the output word (odd-row odd-col for pool, every word for pass-through). out_data, out_sof and out_eol are registered together.
- Throughput: one input word per cycle sustained, back-to-back with no gaps. Idle cycles between words are allowed and must not advance counters.
- Output rate: at most 1 word per 4 inputs in pool mode. out_valid is never asserted on consecutive cycles in pool mode unless inputs allow it.
- Simultaneous sof and completing word: impossible by construction, because sof forces col=0, which is even.
- Async reset mid-frame: all outputs drop to reset values immediately. The next frame requires a fresh in_sof.

## Test plan
- Pool, relu on, W=16: row0 = 1.0 (0x3F80), 2.0 (0x4000), repeated; row1 = 3.0 (0x4040), -1.0 (0xBF80), repeated. Expect 8 outputs of 0x4040, out_sof on the first, out_eol on the 8th, each 1 cycle after the odd-row odd-col input.
- Relu off, pool on: 2x2 block {-1.0, -4.0 (0xC080), -0 (0x8000), -2.0 (0xC000)} -> 0x8000. With relu on, the same block -> 0x0000.
- Pass-through, relu on, W=32: 64 words alternating 0x3F80/0xBF80 -> 64 outputs alternating 0x3F80/0x0000. out_eol on words 31 and 63.
- xres_select=7 with pool on -> treated as W=256: 2 rows of 0x4000 -> 128 outputs, out_eol only on the 128th.
- Second in_sof after 10 words of row1 -> no output from the partial frame. The new frame starts at (0,0) with the new captured config.
- Words before any sof after reset are dropped. clock_areset_n asserted mid-row1 -> outputs 0 at once; the post-reset frame is correct.
